// File: rtl/fsm_rr_arbiter.sv
// fsm_rr_arbiter
//   Round-robin arbiter granting one of N_REQ requesters at a time.
//   Grant is registered and one-hot. A released grant is followed by
//   exactly one dead cycle (gnt=0) before the next owner is chosen, so
//   ownership never changes hands without a break.
//
// Configuration macro: FSM_ARB_TIMEOUT_EN
//   When defined, an owner that keeps requesting for MAX_HOLD cycles is
//   forcibly revoked and the timeout output pulses for one cycle.
//   When undefined, grants are held indefinitely and timeout is tied low.
//
// Ports:
//   clock    in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   req      in   [N_REQ-1:0] request levels, req[i] from agent i
//   gnt      out  [N_REQ-1:0] one-hot grant, all-zero when idle
//   gnt_id   out  [ID_W-1:0]  index of the owner, valid while busy=1
//   busy     out  high while a grant is asserted
//   timeout  out  one-cycle pulse when a grant is revoked by the hold timer
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no grant; arbitrate among requesters at the next edge
// GRANT | one owner holds the grant while its request stays high
// GAP   | single dead cycle after a release; arbitrates like IDLE
module fsm_rr_arbiter #(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 8,
  parameter int ID_W     = $clog2(N_REQ)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             busy,
  output logic             timeout
);

  if (N_REQ < 2 || N_REQ > 16) begin : g_bad_nreq
    $error("fsm_rr_arbiter: N_REQ must be in 2..16");
  end
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
    $error("fsm_rr_arbiter: MAX_HOLD must be in 1..255");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [ID_W-1:0]  last_q, last_d;
  logic             busy_q, busy_d;
  logic [ID_W-1:0]  winner;
  logic             any_req;

  // Rotating search starting just after the previous owner; the previous
  // owner itself is examined last so it only wins when nobody else asks.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      int idx;
      idx = (int'(last_q) + k) % N_REQ;
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        winner  = ID_W'(idx);
      end
    end
  end

`ifdef FSM_ARB_TIMEOUT_EN
  logic [7:0] hold_q, hold_d;
  logic       tmo_q, tmo_d;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    last_d  = last_q;
    busy_d  = busy_q;
`ifdef FSM_ARB_TIMEOUT_EN
    hold_d  = hold_q;
    tmo_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE, ST_GAP: begin
        if (any_req) begin
          state_d = ST_GRANT;
          gnt_d   = N_REQ'(1) << winner;
          id_d    = winner;
          busy_d  = 1'b1;
`ifdef FSM_ARB_TIMEOUT_EN
          hold_d  = 8'd0;
`endif
        end else begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
        end
      end
      ST_GRANT: begin
        if (!req[id_q]) begin
          state_d = ST_GAP;
          gnt_d   = '0;
          busy_d  = 1'b0;
          last_d  = id_q;
        end
`ifdef FSM_ARB_TIMEOUT_EN
        // Counter reads MAX_HOLD-1 in the owner's last permitted cycle.
        else if (hold_q == 8'(MAX_HOLD - 1)) begin
          state_d = ST_GAP;
          gnt_d   = '0;
          busy_d  = 1'b0;
          last_d  = id_q;
          tmo_d   = 1'b1;
        end else begin
          hold_d  = hold_q + 8'd1;
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      last_q  <= ID_W'(N_REQ - 1);
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
    end
  end

`ifdef FSM_ARB_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_q <= 8'd0;
      tmo_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      tmo_q  <= tmo_d;
    end
  end

  assign timeout = tmo_q;
`else
  assign timeout = 1'b0;
`endif

  assign gnt    = gnt_q;
  assign gnt_id = id_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_fsm_rr_arbiter.sv
// tb_fsm_rr_arbiter
//   Directed and randomized checks of fsm_rr_arbiter (N_REQ=4, MAX_HOLD=8)
//   against a behavioural ownership model. Honors FSM_ARB_TIMEOUT_EN.
module tb_fsm_rr_arbiter;

  localparam int N  = 4;
  localparam int MH = 8;
  localparam int IW = $clog2(N);

  logic          clock;
  logic          reset_n;
  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_id;
  logic          busy;
  logic          timeout;

  fsm_rr_arbiter #(.N_REQ(N), .MAX_HOLD(MH)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (req),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Model: who owns the resource (-1 = nobody), who owned it last,
  // the last reported id, how many edges the owner has held it.
  int m_owner;
  int m_last;
  int m_id;
  int m_held;
  bit m_tmo;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_id    = 0;
    m_held  = 0;
    m_tmo   = 1'b0;
  endtask

  task automatic model_step();
    bit found;
    m_tmo = 1'b0;
    if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (!found && req[c]) begin
          found   = 1'b1;
          m_owner = c;
          m_id    = c;
          m_held  = 1;
        end
      end
    end else if (!req[m_owner]) begin
      m_last  = m_owner;
      m_owner = -1;
    end
`ifdef FSM_ARB_TIMEOUT_EN
    else if (m_held == MH) begin
      m_last  = m_owner;
      m_owner = -1;
      m_tmo   = 1'b1;
    end
`endif
    else begin
      m_held++;
    end
  endtask

  task automatic check_outputs(input string where);
    logic [31:0] exp_gnt;
    exp_gnt = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
    chk({where, ".gnt"},     32'(gnt),     exp_gnt);
    chk({where, ".busy"},    32'(busy),    32'(m_owner >= 0));
    chk({where, ".gnt_id"},  32'(gnt_id),  32'(m_id));
    chk({where, ".timeout"}, 32'(timeout), 32'(m_tmo));
  endtask

  task automatic tick(input string where);
    @(posedge clock);
    model_step();
    #1;
    check_outputs(where);
  endtask

  // Reset asserted between edges; outputs must clear without a clock edge.
  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_outputs("async_rst");
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  logic [N-1:0] order [5];

  initial begin
    order[0] = 4'b0001;
    order[1] = 4'b0010;
    order[2] = 4'b0100;
    order[3] = 4'b1000;
    order[4] = 4'b0001;

    reset_n = 1'b0;
    req     = '0;
    model_reset();
    #7;
    check_outputs("reset");
    @(negedge clock);
    reset_n = 1'b1;

    // Single requester: one-cycle latency, release clears next edge.
    tick("idle");
    req = 4'b0001;
    tick("single");
    chk("single_gnt", 32'(gnt), 32'h1);
    req = 4'b0000;
    tick("single_drop");
    chk("single_drop_gnt", 32'(gnt), 32'h0);

    // Fairness: every owner drops for one cycle while all others request.
    do_reset();
    req = 4'b1111;
    tick("fair");
    chk("fair_order0", 32'(gnt), 32'(order[0]));
    for (int k = 1; k < 5; k++) begin
      req = 4'b1111 & ~N'(1 << m_owner);
      tick("fair_gap");
      chk("fair_gap_gnt", 32'(gnt), 32'h0);
      req = 4'b1111;
      tick("fair");
      chk("fair_order", 32'(gnt), 32'(order[k]));
    end

    // Wrap and skip past an idle index.
    do_reset();
    req = 4'b0100;
    tick("wrap_setup");
    chk("wrap_setup_gnt", 32'(gnt), 32'h4);
    req = 4'b0011;
    tick("wrap_gap");
    tick("wrap");
    chk("wrap_gnt", 32'(gnt), 32'h1);
    req = 4'b0010;
    tick("wrap_gap2");
    req = 4'b0011;
    tick("wrap2");
    chk("wrap2_gnt", 32'(gnt), 32'h2);

    // No preemption: agent 1 keeps the grant while 0 and 3 wait.
    req = 4'b1011;
    for (int k = 0; k < 3; k++) begin
      tick("no_preempt");
      chk("no_preempt_gnt", 32'(gnt), 32'h2);
    end
    req = 4'b1001;
    tick("preempt_gap");
    tick("after_preempt");
    chk("after_preempt_gnt", 32'(gnt), 32'h8);

    // Async reset while agent 2 owns the resource.
    req = 4'b0100;
    tick("rst_setup_gap");
    tick("rst_setup");
    chk("rst_setup_gnt", 32'(gnt), 32'h4);
    do_reset();
    chk("rst_mid_gnt", 32'(gnt), 32'h0);
    req = 4'b1111;
    tick("post_rst");
    chk("post_rst_gnt", 32'(gnt), 32'h1);

    // Long hold by agent 0 with agent 1 waiting.
    do_reset();
    req = 4'b0011;
    for (int i = 0; i < 12; i++) begin
      tick("hold");
`ifdef FSM_ARB_TIMEOUT_EN
      if (i == MH) begin
        chk("hold_timeout", 32'(timeout), 32'h1);
        chk("hold_revoked_gnt", 32'(gnt), 32'h0);
      end
      if (i == MH + 1) chk("hold_next_gnt", 32'(gnt), 32'h2);
`endif
    end
`ifndef FSM_ARB_TIMEOUT_EN
    chk("hold_forever_gnt", 32'(gnt), 32'h1);
    chk("hold_no_timeout", 32'(timeout), 32'h0);
`endif

    // Randomized traffic: sparse requests, then heavy contention.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      req = N'($urandom_range(0, 15));
      tick("rand_sparse");
      if ($urandom_range(0, 63) == 0) do_reset();
    end
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) req = N'($urandom_range(0, 15));
      else                           req = 4'b1111;
      tick("rand_busy");
      if ($urandom_range(0, 127) == 0) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
